// File: rtl/load_store_unit_if.sv
// Data-side request/response and memory bus bundle for the load/store unit.
// The slave modport is the unit itself; the master modport is the core pipeline
// plus data memory that surround it.
interface load_store_unit_if #(
    parameter int REG_WIDTH = 64
);
    // request from the core pipeline
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_is_store;
    logic [2:0]           req_funct3;
    logic [REG_WIDTH-1:0] req_base;
    logic [11:0]          req_offset;
    logic [REG_WIDTH-1:0] req_wdata;

    // completion back to writeback
    logic                 resp_valid;
    logic [REG_WIDTH-1:0] resp_rdata;
    logic                 resp_misaligned;
    logic                 resp_illegal;
    logic [REG_WIDTH-1:0] resp_addr;

    // data-memory port
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemSign;
    logic [1:0]           MemWidth;
    logic [REG_WIDTH-1:0] wdata;
    logic [REG_WIDTH-1:0] full_addr;
    logic [REG_WIDTH-1:0] rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal, resp_addr,
        output MemRead, MemWrite, MemSign, MemWidth, wdata, full_addr
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_base, req_offset, req_wdata, rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal, resp_addr,
        input  MemRead, MemWrite, MemSign, MemWidth, wdata, full_addr
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: takes one request at a time, forms the effective address,
// runs a single native-width memory cycle for aligned accesses and a byte-serial
// sequence (or a fault) for misaligned ones, then pulses a one-cycle response.
module load_store_unit #(
    parameter int REG_WIDTH        = 64,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  lsu
);
    localparam int NBYTES = REG_WIDTH / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_SPLIT  = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]           state_reg;
    logic                 is_store_reg;
    logic [2:0]           funct3_reg;
    logic [REG_WIDTH-1:0] ea_reg;
    logic [REG_WIDTH-1:0] wdata_reg;
    logic [2:0]           cnt_reg;
    logic                 illegal_reg;
    logic                 misaligned_reg;

    logic                 ready;
    logic                 accept;
    logic [REG_WIDTH-1:0] ea_next;
    logic [2:0]           size_mask_next;
    logic [2:0]           last_idx;
    logic                 illegal_next;
    logic                 misaligned_next;
    logic [REG_WIDTH-1:0] asm_flat;
    logic [REG_WIDTH-1:0] load_ext;
    logic                 in_access;
    logic                 in_split;
    logic                 in_resp;

    // size-1 for a funct3 width code; doubles as the alignment mask
    function automatic logic [2:0] size_mask(input logic [1:0] w);
        case (w)
            2'd0:    size_mask = 3'd0;
            2'd1:    size_mask = 3'd1;
            2'd2:    size_mask = 3'd3;
            default: size_mask = 3'd7;
        endcase
    endfunction

    assign ready           = (state_reg == ST_IDLE) && !rst;
    assign accept          = lsu.req_valid && ready;
    assign ea_next         = lsu.req_base + {{(REG_WIDTH-12){lsu.req_offset[11]}}, lsu.req_offset};
    assign size_mask_next  = size_mask(lsu.req_funct3[1:0]);
    assign illegal_next    = lsu.req_is_store ? lsu.req_funct3[2] : (lsu.req_funct3 == 3'b111);
    assign misaligned_next = |(ea_next[2:0] & size_mask_next);
    assign last_idx        = size_mask(funct3_reg[1:0]);

    // Sequencer: latch the request on accept and walk IDLE -> ACCESS/SPLIT -> RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            is_store_reg   <= 1'b0;
            funct3_reg     <= 3'd0;
            ea_reg         <= '0;
            wdata_reg      <= '0;
            cnt_reg        <= 3'd0;
            illegal_reg    <= 1'b0;
            misaligned_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        is_store_reg   <= lsu.req_is_store;
                        funct3_reg     <= lsu.req_funct3;
                        ea_reg         <= ea_next;
                        wdata_reg      <= lsu.req_wdata;
                        cnt_reg        <= 3'd0;
                        illegal_reg    <= illegal_next;
                        // an illegal encoding reports only the illegal flag
                        misaligned_reg <= !illegal_next && misaligned_next && !ALLOW_MISALIGNED;
                        if (illegal_next)
                            state_reg <= ST_RESP;
                        else if (!misaligned_next)
                            state_reg <= ST_ACCESS;
                        else if (ALLOW_MISALIGNED)
                            state_reg <= ST_SPLIT;
                        else
                            state_reg <= ST_RESP;
                    end
                end
                ST_ACCESS: state_reg <= ST_RESP;
                ST_SPLIT: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg == last_idx)
                        state_reg <= ST_RESP;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Load assembly register, one byte lane per generate iteration
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_asm
        logic [7:0] byte_reg;

        // Clear on accept; capture the full lane on an aligned load, or memory
        // byte 0 when the split counter reaches this lane
        always_ff @(posedge clk) begin
            if (rst || accept)
                byte_reg <= 8'd0;
            else if (state_reg == ST_ACCESS && !is_store_reg)
                byte_reg <= lsu.rdata[gi*8 +: 8];
            else if (state_reg == ST_SPLIT && !is_store_reg && cnt_reg == 3'(gi))
                byte_reg <= lsu.rdata[7:0];
        end

        assign asm_flat[gi*8 +: 8] = byte_reg;
    end

    // Extend the assembled value from the access width; re-extending data that
    // memory already extended is harmless, so both paths share this
    always_comb begin
        load_ext = asm_flat;
        case (funct3_reg[1:0])
            2'd0: load_ext = funct3_reg[2] ? {{(REG_WIDTH-8){1'b0}}, asm_flat[7:0]}
                                           : {{(REG_WIDTH-8){asm_flat[7]}}, asm_flat[7:0]};
            2'd1: load_ext = funct3_reg[2] ? {{(REG_WIDTH-16){1'b0}}, asm_flat[15:0]}
                                           : {{(REG_WIDTH-16){asm_flat[15]}}, asm_flat[15:0]};
            2'd2: load_ext = funct3_reg[2] ? {{(REG_WIDTH-32){1'b0}}, asm_flat[31:0]}
                                           : {{(REG_WIDTH-32){asm_flat[31]}}, asm_flat[31:0]};
            default: load_ext = asm_flat;
        endcase
    end

    // Reset gates every output so an aborted split stops writing immediately
    assign in_access = !rst && (state_reg == ST_ACCESS);
    assign in_split  = !rst && (state_reg == ST_SPLIT);
    assign in_resp   = !rst && (state_reg == ST_RESP);

    // Memory port drive: native width in ACCESS, byte lane in SPLIT, idle otherwise
    always_comb begin
        lsu.MemRead   = 1'b0;
        lsu.MemWrite  = 1'b0;
        lsu.MemSign   = 1'b0;
        lsu.MemWidth  = 2'd0;
        lsu.wdata     = '0;
        lsu.full_addr = '0;
        if (in_access) begin
            lsu.MemRead   = !is_store_reg;
            lsu.MemWrite  = is_store_reg;
            lsu.MemWidth  = funct3_reg[1:0];
            lsu.MemSign   = is_store_reg ? 1'b0 : funct3_reg[2];
            lsu.full_addr = ea_reg;
            lsu.wdata     = wdata_reg;
        end else if (in_split) begin
            lsu.MemRead   = !is_store_reg;
            lsu.MemWrite  = is_store_reg;
            lsu.MemWidth  = 2'd0;
            lsu.MemSign   = 1'b1;
            lsu.full_addr = ea_reg + {{(REG_WIDTH-3){1'b0}}, cnt_reg};
            lsu.wdata     = {{(REG_WIDTH-8){1'b0}}, wdata_reg[{cnt_reg, 3'b000} +: 8]};
        end
    end

    // Response fields are only non-zero during the single RESP cycle
    always_comb begin
        lsu.resp_valid      = in_resp;
        lsu.resp_misaligned = in_resp && misaligned_reg;
        lsu.resp_illegal    = in_resp && illegal_reg;
        lsu.resp_addr       = in_resp ? ea_reg : '0;
        lsu.resp_rdata      = '0;
        if (in_resp && !is_store_reg && !illegal_reg && !misaligned_reg)
            lsu.resp_rdata = load_ext;
    end

    assign lsu.req_ready = ready;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a small byte memory, a transaction-level model that
// predicts every memory-port and response value cycle by cycle, and directed
// requests with hand-computed results.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clear = 1'b1;

    logic        req_valid0 = 1'b0;
    logic        req_valid1 = 1'b0;
    logic        r_store = 1'b0;
    logic [2:0]  r_f3 = 3'd0;
    logic [63:0] r_base = '0;
    logic [11:0] r_off = '0;
    logic [63:0] r_wdata = '0;

    int tests = 0;
    int fails = 0;
    int strobes1 = 0;

    logic [7:0] mem [0:511];

    load_store_unit_if #(.REG_WIDTH(64)) if0 ();
    load_store_unit_if #(.REG_WIDTH(64)) if1 ();

    load_store_unit #(.REG_WIDTH(64), .ALLOW_MISALIGNED(1'b1)) dut0 (.clk(clk), .rst(rst), .lsu(if0));
    load_store_unit #(.REG_WIDTH(64), .ALLOW_MISALIGNED(1'b0)) dut1 (.clk(clk), .rst(rst), .lsu(if1));

    assign if0.req_valid    = req_valid0;
    assign if0.req_is_store = r_store;
    assign if0.req_funct3   = r_f3;
    assign if0.req_base     = r_base;
    assign if0.req_offset   = r_off;
    assign if0.req_wdata    = r_wdata;
    assign if1.req_valid    = req_valid1;
    assign if1.req_is_store = r_store;
    assign if1.req_funct3   = r_f3;
    assign if1.req_base     = r_base;
    assign if1.req_offset   = r_off;
    assign if1.req_wdata    = r_wdata;
    assign if1.rdata        = '0;

    always #5 clk = ~clk;

    // combinational raw little-endian read of eight bytes at full_addr
    always_comb begin
        if0.rdata = '0;
        for (int k = 0; k < 8; k++)
            if0.rdata[k*8 +: 8] = mem[9'(if0.full_addr + 64'(k))];
    end

    // memory write port; also loads the known start pattern
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int k = 0; k < 512; k++)
                mem[k] <= 8'(k) ^ 8'hA5;
        end else if (if0.MemWrite) begin
            for (int k = 0; k < 8; k++)
                if (k < (1 << if0.MemWidth))
                    mem[9'(if0.full_addr + 64'(k))] <= if0.wdata[k*8 +: 8];
        end
    end

    // the faulting-configuration instance must never touch memory
    always @(negedge clk) begin
        if (if1.MemRead || if1.MemWrite)
            strobes1++;
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: on accept, expand the request into the sequence of
    // per-cycle expectations it must produce; one entry retires per cycle.
    // ------------------------------------------------------------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  width;
        logic        sign;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        chk_wd;
        logic        rv;
        logic [63:0] rdat;
        logic [63:0] raddr;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    logic model_acc;

    function automatic exp_t idle_exp();
        exp_t e;
        e.rd = 0; e.wr = 0; e.width = 0; e.sign = 0; e.addr = 0; e.wd = 0;
        e.chk_wd = 1; e.rv = 0; e.rdat = 0; e.raddr = 0; e.ill = 0;
        return e;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] ea, input logic [2:0] f3);
        int sz;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        v = '0;
        for (int i = 0; i < sz; i++)
            v[i*8 +: 8] = mem[9'(ea + 64'(i))];
        if (!f3[2] && sz < 8 && v[sz*8-1])
            for (int b = sz*8; b < 64; b++)
                v[b] = 1'b1;
        return v;
    endfunction

    function automatic void model_accept();
        exp_t e;
        logic [63:0] ea;
        logic st, ill, mis;
        logic [2:0] f3;
        int sz;
        st  = if0.req_is_store;
        f3  = if0.req_funct3;
        ea  = if0.req_base + {{52{if0.req_offset[11]}}, if0.req_offset};
        sz  = 1 << f3[1:0];
        ill = st ? f3[2] : (f3 == 3'b111);
        mis = (ea % 64'(sz)) != 0;
        if (!ill) begin
            if (mis) begin
                for (int i = 0; i < sz; i++) begin
                    e = idle_exp();
                    e.rd = !st; e.wr = st; e.width = 2'd0; e.sign = 1'b1;
                    e.addr = ea + 64'(i);
                    e.wd = (if0.req_wdata >> (8*i)) & 64'hFF;
                    e.chk_wd = st;
                    exp_q.push_back(e);
                end
            end else begin
                e = idle_exp();
                e.rd = !st; e.wr = st; e.width = f3[1:0]; e.sign = st ? 1'b0 : f3[2];
                e.addr = ea; e.wd = if0.req_wdata; e.chk_wd = st;
                exp_q.push_back(e);
            end
        end
        e = idle_exp();
        e.rv = 1'b1;
        e.rdat = (ill || st) ? 64'd0 : model_load(ea, f3);
        e.raddr = ea;
        e.ill = ill;
        exp_q.push_back(e);
    endfunction

    function automatic void model_compare();
        exp_t e;
        logic rdy;
        e = idle_exp();
        rdy = !rst && (exp_q.size() == 0);
        if (!rst && exp_q.size() != 0)
            e = exp_q[0];
        chk("m_req_ready",  64'(if0.req_ready), 64'(rdy));
        chk("m_MemRead",    64'(if0.MemRead), 64'(e.rd));
        chk("m_MemWrite",   64'(if0.MemWrite), 64'(e.wr));
        chk("m_MemWidth",   64'(if0.MemWidth), 64'(e.width));
        chk("m_MemSign",    64'(if0.MemSign), 64'(e.sign));
        chk("m_full_addr",  if0.full_addr, e.addr);
        if (e.chk_wd)
            chk("m_wdata",  if0.wdata, e.wd);
        chk("m_resp_valid", 64'(if0.resp_valid), 64'(e.rv));
        chk("m_resp_rdata", if0.resp_rdata, e.rdat);
        chk("m_resp_addr",  if0.resp_addr, e.raddr);
        chk("m_resp_ill",   64'(if0.resp_illegal), 64'(e.ill));
        chk("m_resp_mis",   64'(if0.resp_misaligned), 64'd0);
    endfunction

    // single compare process: advance the model at the edge, check at the falling edge
    always begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            model_acc = if0.req_valid && (exp_q.size() == 0);
            if (exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (model_acc)
                model_accept();
        end
        @(negedge clk);
        model_compare();
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic issue(input bit sel, input logic st, input logic [2:0] f3,
                         input logic [63:0] base, input logic [11:0] off, input logic [63:0] wd,
                         output int lat, output logic [63:0] rd, output logic [63:0] ra,
                         output logic mis, output logic ill);
        int n;
        r_store = st; r_f3 = f3; r_base = base; r_off = off; r_wdata = wd;
        if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? if1.req_ready : if0.req_ready) && n < 50);
        chk("accept_wait", 64'(n < 50), 64'd1);
        @(posedge clk);
        #1;
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(sel ? if1.resp_valid : if0.resp_valid) && lat < 50);
        rd  = sel ? if1.resp_rdata : if0.resp_rdata;
        ra  = sel ? if1.resp_addr : if0.resp_addr;
        mis = sel ? if1.resp_misaligned : if0.resp_misaligned;
        ill = sel ? if1.resp_illegal : if0.resp_illegal;
        $display("[TB] req sel=%0d st=%0d f3=%0d ea=%h -> lat=%0d rdata=%h mis=%0d ill=%0d",
                 sel, st, f3, ra, lat, rd, mis, ill);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, n, n_resp;
        logic [63:0] rd, ra;
        logic mis, ill;
        logic [7:0] pre [0:4];

        repeat (3) @(posedge clk);
        #1 mem_clear = 1'b0;
        @(negedge clk);
        chk("reset_req_ready",  64'(if0.req_ready), 64'd0);
        chk("reset_resp_valid", 64'(if0.resp_valid), 64'd0);
        chk("reset_MemWrite",   64'(if0.MemWrite), 64'd0);
        chk("reset_full_addr",  if0.full_addr, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // aligned double store then load
        issue(0, 1, 3'b011, 64'h40, 12'h000, 64'h8877665544332211, lat, rd, ra, mis, ill);
        chk("sd_lat", 64'(lat), 64'd2);
        issue(0, 0, 3'b011, 64'h40, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("ld_rdata", rd, 64'h8877665544332211);
        chk("ld_lat", 64'(lat), 64'd2);
        chk("ld_addr", ra, 64'h40);

        // sign/zero extension
        issue(0, 1, 3'b000, 64'h10, 12'h000, 64'h80, lat, rd, ra, mis, ill);
        issue(0, 0, 3'b000, 64'h20, 12'hFF0, 64'h0, lat, rd, ra, mis, ill);
        chk("lb_rdata", rd, 64'hFFFFFFFFFFFFFF80);
        chk("lb_addr", ra, 64'h10);
        issue(0, 0, 3'b100, 64'h20, 12'hFF0, 64'h0, lat, rd, ra, mis, ill);
        chk("lbu_rdata", rd, 64'h80);
        issue(0, 1, 3'b010, 64'h20, 12'h000, 64'h80000000, lat, rd, ra, mis, ill);
        issue(0, 0, 3'b110, 64'h20, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("lwu_rdata", rd, 64'h0000000080000000);
        issue(0, 0, 3'b010, 64'h20, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("lw_rdata", rd, 64'hFFFFFFFF80000000);

        // misaligned split store and loads
        issue(0, 1, 3'b010, 64'h0, 12'h003, 64'hDEADBEEF, lat, rd, ra, mis, ill);
        chk("sw_split_lat", 64'(lat), 64'd5);
        chk("sw_split_mem", 64'({mem[6], mem[5], mem[4], mem[3]}), 64'hDEADBEEF);
        issue(0, 0, 3'b011, 64'h0, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("ld_after_split", rd, 64'hA2DEADBEEFA7A4A5);
        issue(0, 0, 3'b001, 64'h5, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("lh_split_rdata", rd, 64'hFFFFFFFFFFFFDEAD);
        chk("lh_split_lat", 64'(lat), 64'd3);

        // address wrap
        issue(0, 0, 3'b100, 64'hFFFFFFFFFFFFFFFF, 12'h002, 64'h0, lat, rd, ra, mis, ill);
        chk("wrap_rdata", rd, 64'hA4);
        chk("wrap_addr", ra, 64'h1);

        // illegal encodings
        issue(0, 1, 3'b100, 64'h80, 12'h000, 64'h55, lat, rd, ra, mis, ill);
        chk("ill_store_flag", 64'(ill), 64'd1);
        chk("ill_store_lat", 64'(lat), 64'd1);
        chk("ill_store_nowrite", 64'(mem[9'h80]), 64'h25);
        issue(0, 0, 3'b111, 64'h40, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("ill_load_flag", 64'(ill), 64'd1);
        chk("ill_load_rdata", rd, 64'd0);

        // faulting configuration
        issue(1, 0, 3'b001, 64'h100, 12'h001, 64'h0, lat, rd, ra, mis, ill);
        chk("fault_mis", 64'(mis), 64'd1);
        chk("fault_ill", 64'(ill), 64'd0);
        chk("fault_lat", 64'(lat), 64'd1);
        chk("fault_addr", ra, 64'h101);
        chk("fault_rdata", rd, 64'd0);
        chk("fault_no_strobe", 64'(strobes1), 64'd0);

        // back-to-back with req_valid held high
        r_store = 0; r_f3 = 3'b011; r_base = 64'h40; r_off = 12'h000; r_wdata = 64'h0;
        req_valid0 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0.req_ready && n < 50);
        @(posedge clk);
        #1;
        r_f3 = 3'b100; r_base = 64'h10;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0.resp_valid && n < 50);
        chk("b2b_first_rdata", if0.resp_rdata, 64'h8877665544332211);
        chk("b2b_first_lat", 64'(n), 64'd2);
        $display("[TB] b2b first lat=%0d rdata=%h", n, if0.resp_rdata);
        @(negedge clk);
        chk("b2b_ready_after_resp", 64'(if0.req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0.resp_valid && n < 50);
        chk("b2b_second_rdata", if0.resp_rdata, 64'h80);
        chk("b2b_second_lat", 64'(n), 64'd2);
        $display("[TB] b2b second lat=%0d rdata=%h", n, if0.resp_rdata);

        // reset during byte 3 of a split double store
        for (int k = 0; k < 5; k++)
            pre[k] = mem[9'(12 + k)];
        r_store = 1; r_f3 = 3'b011; r_base = 64'h9; r_off = 12'h000; r_wdata = 64'h1122334455667788;
        req_valid0 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!if0.req_ready && n < 50);
        @(posedge clk);
        #1 req_valid0 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_split_MemWrite", 64'(if0.MemWrite), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        n_resp = 0;
        repeat (10) begin
            @(negedge clk);
            if (if0.resp_valid) n_resp++;
        end
        chk("rst_split_no_resp", 64'(n_resp), 64'd0);
        chk("rst_split_written", 64'({mem[9'h0B], mem[9'h0A], mem[9'h09]}), 64'h667788);
        for (int k = 0; k < 5; k++)
            chk("rst_split_untouched", 64'(mem[9'(12 + k)]), 64'(pre[k]));
        $display("[TB] reset mid-split: resp pulses=%0d", n_resp);
        issue(0, 0, 3'b011, 64'h8, 12'h000, 64'h0, lat, rd, ra, mis, ill);
        chk("ld_after_abort", rd, 64'hAAABA8A9667788AD);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
